// File: rtl/ext_copy_pkg.sv
// Shared types and constants for the external-master block copy engine.
package ext_copy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } copy_state_e;

  localparam logic [3:0] BE_ALL    = 4'hF;
  localparam int         ADDR_STEP = 4;

endpackage

// File: rtl/copy_fifo.sv
// First-word-fall-through staging FIFO between the read and write bursts.
module copy_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full)  wr_d = wr_q + (AW+1)'(1);
      if (pop  && !empty) rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ext_master_copy_engine.sv
// Block copy master for the Computer_System external-master bridge: batches of
// reads are staged in a FIFO, then written back out, one request at a time.
module ext_master_copy_engine
  import ext_copy_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] bus_address,
  output logic [3:0]        bus_byte_enable,
  output logic              bus_read,
  output logic              bus_write,
  output logic [DATA_W-1:0] bus_write_data,
  input  logic              bus_acknowledge,
  input  logic [DATA_W-1:0] bus_read_data
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  copy_state_e       state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  rd_left_q, rd_left_d, words_done_q, words_done_d;
  logic [BW-1:0]     batch_q, batch_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              error_q, error_d;
  logic              abort;
  logic              tmo_last;
  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  assign tmo_last = (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rd_left_d    = rd_left_q;
    words_done_d = words_done_q;
    batch_d      = batch_q;
    error_d      = error_q;
    abort        = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    tmo_d        = req_q ? tmo_q + TW'(1) : '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          error_d      = 1'b0;
          words_done_d = '0;
          if (word_count != '0) begin
            src_d     = src_addr & ADDR_MASK;
            dst_d     = dst_addr & ADDR_MASK;
            rd_left_d = word_count;
            batch_d   = '0;
            req_d     = 1'b1;
            state_d   = READ;
          end else begin
            state_d = FINISH;
          end
        end
      end
      // The request always drops for one cycle after an ack; a state change
      // happens on the ack itself so that idle cycle lands in the new state.
      READ: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (bus_acknowledge) begin
          req_d     = 1'b0;
          fifo_push = !fifo_full;
          src_d     = src_q + ADDR_W'(ADDR_STEP);
          rd_left_d = rd_left_q - LEN_W'(1);
          batch_d   = batch_q + BW'(1);
          if (batch_q == BW'(FIFO_DEPTH - 1) || rd_left_q == LEN_W'(1)) state_d = WRITE;
        end else if (tmo_last) begin
          abort = 1'b1;
        end
      end
      WRITE: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (bus_acknowledge) begin
          req_d        = 1'b0;
          fifo_pop     = !fifo_empty;
          dst_d        = dst_q + ADDR_W'(ADDR_STEP);
          words_done_d = words_done_q + LEN_W'(1);
          batch_d      = batch_q - BW'(1);
          if (batch_q == BW'(1)) state_d = (rd_left_q != '0) ? READ : FINISH;
        end else if (tmo_last) begin
          abort = 1'b1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      req_d      = 1'b0;
      error_d    = 1'b1;
      fifo_flush = 1'b1;
      batch_d    = '0;
      state_d    = FINISH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      rd_left_q    <= '0;
      words_done_q <= '0;
      batch_q      <= '0;
      tmo_q        <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rd_left_q    <= rd_left_d;
      words_done_q <= words_done_d;
      batch_q      <= batch_d;
      tmo_q        <= tmo_d;
      error_q      <= error_d;
    end
  end

  copy_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .flush  (fifo_flush),
    .din    (bus_read_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign busy            = (state_q == READ) || (state_q == WRITE);
  assign done            = (state_q == FINISH);
  assign error           = error_q;
  assign words_done      = words_done_q;
  assign bus_read        = req_q && (state_q == READ);
  assign bus_write       = req_q && (state_q == WRITE);
  assign bus_byte_enable = req_q ? BE_ALL : 4'h0;
  assign bus_address     = bus_read ? src_q : (bus_write ? dst_q : '0);
  assign bus_write_data  = bus_write ? fifo_dout : '0;

endmodule

// File: tb/tb_ext_master_copy_engine.sv
// Bench for ext_master_copy_engine: bus memory responder, batch-level copy
// model, a vector table of copies plus random and reset sequences.
module tb_ext_master_copy_engine;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int FD = 8;
  localparam int TO = 16;

  logic          clk, reset_n, start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] word_count;
  logic          busy, done, error;
  logic [LW-1:0] words_done;
  logic [AW-1:0] bus_address;
  logic [3:0]    bus_byte_enable;
  logic          bus_read, bus_write, bus_acknowledge;
  logic [DW-1:0] bus_write_data, bus_read_data;

  ext_master_copy_engine #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .bus_address(bus_address), .bus_byte_enable(bus_byte_enable),
    .bus_read(bus_read), .bus_write(bus_write), .bus_write_data(bus_write_data),
    .bus_acknowledge(bus_acknowledge), .bus_read_data(bus_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    int            cnt;
    int            dly;
    int            withhold;
    int            restart;
    int            exp_words;
    bit            exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];
  txn_t          log_q[$];
  txn_t          exp_q[$];

  // Responder state
  int            cyc = 0;
  int            ack_delay = 0;
  bit            rand_delay = 0;
  bit            spray = 0;
  int            withhold_n = 0;
  int            rd_num = 0;
  int            last_end = -1;
  int            gap_viol = 0;
  int            proto_viol = 0;
  int            drops = 0;
  int            drop_len = 0;
  bit            in_req = 0;
  bit            withheld = 0;
  int            wait_cnt = 0;
  int            cur_delay = 0;
  bit            req_wr = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;

  function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave memory on the bridge: acks after a programmable delay and logs
  // every completed transaction; also watches the request handshake rules.
  initial begin
    bus_acknowledge = 1'b0;
    bus_read_data   = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus_acknowledge = 1'b0;
      bus_read_data   = 32'hDEADBEEF;
      if (bus_read && bus_write) proto_viol++;
      if (bus_byte_enable != ((bus_read || bus_write) ? 4'hF : 4'h0)) proto_viol++;
      if (bus_read || bus_write) begin
        if (!in_req) begin
          in_req   = 1'b1;
          wait_cnt = 0;
          req_wr   = bus_write;
          req_addr = bus_address;
          req_data = bus_write_data;
          if (last_end >= 0 && cyc - last_end != 2) gap_viol++;
          if (bus_read) rd_num++;
          withheld  = bus_read && (rd_num == withhold_n);
          cur_delay = rand_delay ? int'($urandom_range(0, 4)) : ack_delay;
        end else begin
          wait_cnt++;
          if (bus_write != req_wr || bus_address != req_addr ||
              (req_wr && bus_write_data != req_data)) proto_viol++;
        end
        if (!withheld && wait_cnt == cur_delay) begin
          bus_acknowledge = 1'b1;
          if (req_wr) begin
            mem[req_addr] = req_data;
            log_q.push_back('{1'b1, req_addr, req_data});
          end else begin
            bus_read_data = rd_mem(req_addr);
            log_q.push_back('{1'b0, req_addr, bus_read_data});
          end
          in_req   = 1'b0;
          last_end = cyc;
        end
      end else begin
        if (in_req) begin
          in_req   = 1'b0;
          drops++;
          drop_len = wait_cnt + 1;
        end
        if (spray) bus_acknowledge = 1'($urandom_range(0, 1));
      end
    end
  end

  // Expected bus trace: whole batches of up to FD reads then the same data
  // written back, addresses stepping by 4 modulo 2^AW.
  task automatic build_exp(input logic [AW-1:0] s0, input logic [AW-1:0] d0,
                           input int n, input int withhold);
    logic [AW-1:0] s, d;
    logic [DW-1:0] data_q[$];
    int            left, chunk;
    exp_q.delete();
    s    = s0 & ~30'h3;
    d    = d0 & ~30'h3;
    left = n;
    while (left > 0) begin
      chunk = (left < FD) ? left : FD;
      data_q.delete();
      for (int i = 0; i < chunk; i++) begin
        data_q.push_back(rd_mem(s));
        exp_q.push_back('{1'b0, s, data_q[i]});
        s += 30'd4;
      end
      for (int i = 0; i < chunk; i++) begin
        exp_q.push_back('{1'b1, d, data_q[i]});
        d += 30'd4;
      end
      left -= chunk;
    end
    if (withhold > 0) while (exp_q.size() > withhold - 1) void'(exp_q.pop_back());
  endtask

  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    start      = 1'b1;
    src_addr   = s;
    dst_addr   = d;
    word_count = LW'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_clears_error", error, 1'b0);
  endtask

  task automatic run_copy(input string tag, input vec_t v);
    bit got;
    int ndone, busy_seen, busy_after, bad, nbad;
    logic [LW-1:0] wd;
    logic          er;
    build_exp(v.src, v.dst, v.cnt, v.withhold);
    log_q.delete();
    gap_viol = 0; proto_viol = 0; drops = 0; last_end = -1; rd_num = 0;
    ack_delay = v.dly; withhold_n = v.withhold;
    do_start(v.src, v.dst, v.cnt);
    if (v.cnt == 0) begin
      check({tag, "_zero_done_next"}, done, 1'b1);
      check({tag, "_zero_busy"}, busy, 1'b0);
    end else begin
      check({tag, "_read_after_start"}, bus_read, 1'b1);
    end
    got = 0; ndone = 0; busy_seen = 0; wd = '0; er = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      if (v.restart > 0 && k == v.restart) begin
        start = 1'b1; src_addr = 30'h9000; dst_addr = 30'h9800; word_count = 16'd3;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_seen = 1;
      if (done) begin
        got = 1; ndone = 1; wd = words_done; er = error;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, got, 1'b1);
    busy_after = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (busy) busy_after++;
    end
    check({tag, "_done_pulses"}, ndone, 1);
    check({tag, "_words_done"}, wd, v.exp_words);
    check({tag, "_error"}, er, v.exp_err);
    check({tag, "_error_sticky"}, error, v.exp_err);
    check({tag, "_busy_seen"}, busy_seen, (v.cnt != 0));
    check({tag, "_busy_after"}, busy_after, 0);
    check({tag, "_txn_count"}, log_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      if (bad == 0 && (log_q[i].wr != exp_q[i].wr || log_q[i].addr != exp_q[i].addr ||
                       log_q[i].data != exp_q[i].data)) begin
        bad = i + 1;
        $display("  %s txn %0d: got wr=%0d a=%0h d=%0h, expected wr=%0d a=%0h d=%0h", tag, i,
                 log_q[i].wr, log_q[i].addr, log_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    check({tag, "_first_bad_txn"}, bad, 0);
    nbad = 0;
    foreach (exp_q[i]) if (exp_q[i].wr && rd_mem(exp_q[i].addr) != exp_q[i].data) nbad++;
    check({tag, "_dst_mem_bad"}, nbad, 0);
    check({tag, "_gap_viol"}, gap_viol, 0);
    check({tag, "_proto_viol"}, proto_viol, 0);
    check({tag, "_drops"}, drops, (v.withhold > 0));
    if (v.withhold > 0) check({tag, "_drop_len"}, drop_len, TO);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_words_done"}, words_done, '0);
    check({tag, "_bus_ctl"}, {bus_read, bus_write, bus_byte_enable}, '0);
    check({tag, "_bus_addr"}, bus_address, '0);
    check({tag, "_bus_wdata"}, bus_write_data, '0);
  endtask

  vec_t vecs[10];
  vec_t rv;

  initial begin
    vecs[0] = '{30'h100,      30'h200,  3, 2,  0, 0, 3,  1'b0};
    vecs[1] = '{30'h1000,     30'h2000, 20, 0, 0, 0, 20, 1'b0};
    vecs[2] = '{30'h3000,     30'h4000, 0, 0,  0, 0, 0,  1'b0};
    vecs[3] = '{30'h5000,     30'h6000, 10, 0, 5, 0, 0,  1'b1};
    vecs[4] = '{30'h7000,     30'h7800, 2, 0,  0, 0, 2,  1'b0};
    vecs[5] = '{30'h3FFFFFF8, 30'h800,  4, 1,  0, 0, 4,  1'b0};
    vecs[6] = '{30'h503,      30'h603,  8, 3,  0, 0, 8,  1'b0};
    vecs[7] = '{30'h8000,     30'h8800, 2, 15, 0, 0, 2,  1'b0};
    vecs[8] = '{30'hA000,     30'hA800, 6, 1,  0, 5, 6,  1'b0};
    vecs[9] = '{30'hB000,     30'hB800, 9, 1,  0, 0, 9,  1'b0};

    start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_copy($sformatf("vec%0d", i), vecs[i]);

    // Random copies with random ack latency and stray acks between requests.
    rand_delay = 1; spray = 1;
    for (int i = 0; i < 6; i++) begin
      rv.src = 30'($urandom_range(0, 32'h3FFFF)) << 2;
      rv.dst = rv.src + 30'h100000;
      rv.cnt = int'($urandom_range(1, 30));
      rv.dly = 0; rv.withhold = 0; rv.restart = 0;
      rv.exp_words = rv.cnt; rv.exp_err = 1'b0;
      run_copy($sformatf("rnd%0d", i), rv);
    end
    rand_delay = 0; spray = 0;

    // Reset asserted in the middle of the write burst of a 12-word copy.
    log_q.delete(); ack_delay = 0; withhold_n = 0; last_end = -1; rd_num = 0;
    do_start(30'hC000, 30'hC800, 12);
    for (int k = 0; k < 500 && words_done < 16'd2; k++) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid_write_reached", {busy, words_done}, {1'b1, 16'd2});
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rst_release");
    rv = '{30'hC000, 30'hD000, 12, 0, 0, 0, 12, 1'b0};
    run_copy("post_reset", rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_master_copy_engine.md
Name: ext_master_copy_engine

Overview:
FPGA-side bus master that drives the Computer_System external-master bridge port (address/byte_enable/read/write/write_data in, acknowledge/read_data out). On a start command it copies a block of 32-bit words from a source byte address to a destination byte address through the HPS/Avalon address space. Reads are staged in a small FIFO, so each bus turnaround is amortised over a batch of words.

Parameters:
ADDR_W, 30, bridge byte-address width
DATA_W, 32, bridge data width
LEN_W, 16, word-count width
FIFO_DEPTH, 8, staging FIFO depth in words (power of 2, >=2)
TIMEOUT_CYC, 1024, max cycles a request may wait for acknowledge

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle command pulse
src_addr  in  ADDR_W  source byte address; bits [1:0] ignored
dst_addr  in  ADDR_W  destination byte address; bits [1:0] ignored
word_count  in  LEN_W  number of words to copy
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of transfer (normal or aborted)
error  out  1  sticky timeout flag; cleared by next accepted start
words_done  out  LEN_W  words written so far
bus_address  out  ADDR_W  to external_master address
bus_byte_enable  out  4  to byte_enable; constant 4'hF while a request is active, 0 otherwise
bus_read  out  1  to read
bus_write  out  1  to write
bus_write_data  out  DATA_W  to write_data
bus_acknowledge  in  1  from acknowledge
bus_read_data  in  DATA_W  from read_data; valid only in the ack cycle

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0.
- Bus protocol: a request holds read or write, address, byte_enable and data stable until the first cycle with bus_acknowledge=1. The request is low in the cycle after the ack. There is exactly one idle cycle between consecutive requests. read and write are never high together.
- Read data is captured into the FIFO in the ack cycle.
- FSM states: IDLE, READ, WRITE, FINISH.
- IDLE: start with word_count>0 latches src/dst with [1:0]=0, latches the count, clears error and words_done, sets busy=1 and moves to READ. bus_read is high in the cycle after start.
- IDLE, start with word_count=0: busy stays 0. done pulses in the next cycle. No bus activity.
- READ: issue reads at the source address, incrementing it by 4 after each ack. Leave for WRITE when the FIFO is full or all words have been read.
- WRITE: pop the FIFO head onto bus_write_data and write at the destination address, incrementing it by 4 and words_done by 1 per ack. When the FIFO is empty, go to READ if words remain, otherwise FINISH.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- Addresses increment modulo 2^ADDR_W (wrap to 0, no error).
- Timeout: a per-request counter is cleared at request assertion. If it reaches TIMEOUT_CYC without an ack, drop the request, set error=1, flush the FIFO and go to FINISH. words_done keeps the count of completed writes.
- An ack in the same cycle the timeout is reached counts as success.
- start while busy is ignored. Any other bus_acknowledge while no request is active is ignored.
- Asynchronous reset mid-transfer aborts immediately to reset values. No done pulse.
- Throughput without wait states: 2 cycles per bus transaction.

Decomposition:
- Package ext_copy_pkg holds:
  - FSM state enum (IDLE, READ, WRITE, FINISH)
  - BE_ALL=4'hF
  - ADDR_STEP=4
- Sub-module copy_fifo: synchronous FWFT FIFO with params WIDTH and DEPTH, ports push/pop/din/dout/full/empty/flush, on the same clk/reset_n.
- FSM, address/count registers and timeout counter live in the top.

Test Plan:
- Copy 3 words, src=0x100, dst=0x200, ack 2 cycles after each request:
  - reads at 0x100/0x104/0x108, then writes at 0x200/0x204/0x208 with identical data
  - words_done=3, done pulses once, error=0.
- Copy 20 words, FIFO_DEPTH=8, zero-wait ack:
  - bus sequence 8R,8W,8R,8W,4R,4W
  - destination memory equals source memory
  - one idle cycle between every pair of requests.
- start with word_count=0: no bus_read/bus_write ever high; done=1 exactly one cycle after start; busy stays 0.
- Ack withheld on the 5th read of 10, TIMEOUT_CYC=16:
  - request drops after 16 cycles
  - error=1, done pulses, words_done=0
  - next start clears error.
- Second start pulsed during a busy transfer: ignored; original addresses and count complete unchanged.
- reset_n asserted mid-WRITE of a 12-word copy: all outputs 0 asynchronously; a fresh copy after release completes correctly.
